// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - circular-buffer snake body store with serial self-collision scan
module snake_body_store #(
  parameter int X_BITS   = 6,
  parameter int Y_BITS   = 6,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 30,
  parameter int START_Y  = 22
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              clear_in,
  input  logic              move_in,
  input  logic              grow_in,
  input  logic [X_BITS-1:0] new_x_in,
  input  logic [Y_BITS-1:0] new_y_in,
  input  logic [ADDR_W-1:0] query_idx_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              self_hit_out,
  output logic              full_out,
  output logic [ADDR_W:0]   length_out,
  output logic [X_BITS-1:0] head_x_out,
  output logic [Y_BITS-1:0] head_y_out,
  output logic [X_BITS-1:0] query_x_out,
  output logic [Y_BITS-1:0] query_y_out,
  output logic              query_valid_out
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SCAN, S_COMMIT} state_t;

  state_t state, state_nx;

  logic [X_BITS-1:0] mem_x [DEPTH];
  logic [Y_BITS-1:0] mem_y [DEPTH];

  logic [ADDR_W-1:0] hp;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] scan_cnt;
  logic [ADDR_W-1:0] scan_last;
  logic [X_BITS-1:0] lat_x;
  logic [Y_BITS-1:0] lat_y;
  logic              lat_g;
  logic              match;

  logic              grow_eff;
  logic              accept;
  logic [ADDR_W:0]   scan_len;
  logic              init_last;
  logic [ADDR_W-1:0] scan_addr;
  logic              seg_hit;
  logic [ADDR_W-1:0] hp_dec;
  logic [ADDR_W-1:0] q_addr;
  logic              q_valid;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [X_BITS-1:0] wr_x;
  logic [Y_BITS-1:0] wr_y;

  assign full_out  = (length_out == (ADDR_W+1)'(DEPTH));
  assign grow_eff  = grow_in & ~full_out;
  assign accept    = (state == S_IDLE) && move_in && (length_out != '0)
                     && !self_hit_out && !clear_in;
  // Without growth the tail cell vacates in the same step, so it is not compared.
  assign scan_len  = length_out - (ADDR_W+1)'(1) + {{ADDR_W{1'b0}}, grow_eff};
  assign init_last = (init_cnt == ADDR_W'(INIT_LEN - 1));
  assign scan_addr = hp + scan_cnt;
  assign seg_hit   = (mem_x[scan_addr] == lat_x) && (mem_y[scan_addr] == lat_y);
  assign hp_dec    = hp - ADDR_W'(1);
  assign q_addr    = hp + query_idx_in;
  assign q_valid   = ({1'b0, query_idx_in} < length_out);

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_in) begin
      state_nx = S_INIT;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_nx = (scan_len == '0) ? S_COMMIT : S_SCAN;
        S_INIT:   if (init_last) state_nx = S_IDLE;
        S_SCAN:   if (scan_cnt == scan_last) state_nx = S_COMMIT;
        S_COMMIT: state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_out = (state != S_IDLE);
    wr_en    = 1'b0;
    wr_addr  = hp_dec;
    wr_x     = lat_x;
    wr_y     = lat_y;
    // A clear in the same cycle suppresses any pending write.
    if (!clear_in) begin
      if (state == S_INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_cnt;
        wr_x    = X_BITS'(START_X) - X_BITS'(init_cnt);
        wr_y    = Y_BITS'(START_Y);
      end else if (state == S_COMMIT && !match) begin
        wr_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem_x[wr_addr] <= wr_x;
      mem_y[wr_addr] <= wr_y;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      hp              <= '0;
      length_out      <= '0;
      init_cnt        <= '0;
      scan_cnt        <= '0;
      scan_last       <= '0;
      lat_x           <= '0;
      lat_y           <= '0;
      lat_g           <= 1'b0;
      match           <= 1'b0;
      self_hit_out    <= 1'b0;
      done_out        <= 1'b0;
      head_x_out      <= '0;
      head_y_out      <= '0;
      query_x_out     <= '0;
      query_y_out     <= '0;
      query_valid_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (clear_in) begin
        hp           <= '0;
        length_out   <= '0;
        init_cnt     <= '0;
        match        <= 1'b0;
        self_hit_out <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              lat_x     <= new_x_in;
              lat_y     <= new_y_in;
              lat_g     <= grow_eff;
              match     <= 1'b0;
              scan_cnt  <= '0;
              scan_last <= scan_len[ADDR_W-1:0] - ADDR_W'(1);
            end
          end
          S_INIT: begin
            init_cnt <= init_cnt + ADDR_W'(1);
            if (init_last) begin
              length_out <= (ADDR_W+1)'(INIT_LEN);
              head_x_out <= X_BITS'(START_X);
              head_y_out <= Y_BITS'(START_Y);
              done_out   <= 1'b1;
            end
          end
          S_SCAN: begin
            scan_cnt <= scan_cnt + ADDR_W'(1);
            if (seg_hit) match <= 1'b1;
          end
          S_COMMIT: begin
            done_out <= 1'b1;
            if (match) begin
              self_hit_out <= 1'b1;
            end else begin
              hp         <= hp_dec;
              head_x_out <= lat_x;
              head_y_out <= lat_y;
              if (lat_g) length_out <= length_out + (ADDR_W+1)'(1);
            end
          end
          default: ;
        endcase
      end
      query_valid_out <= q_valid;
      query_x_out     <= q_valid ? mem_x[q_addr] : '0;
      query_y_out     <= q_valid ? mem_y[q_addr] : '0;
    end
  end

endmodule

// File: doc/snake_body_store.md
SNAKE_BODY_STORE -- requirements
Module: snake_body_store

Interface
REQ-001 Parameters SHALL be: X_BITS, default 6, x-coordinate width; Y_BITS, default 6, y-coordinate width; DEPTH, default 64, segment capacity (power of two); ADDR_W, default 6, log2(DEPTH); INIT_LEN, default 3, length after clear (1..DEPTH); START_X, default 30, initial head x (>= INIT_LEN-1); START_Y, default 22, initial head y.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports, in order:
- sys_clk  in  1  sole clock, rising edge.
- sys_reset  in  1  asynchronous reset, active high.
- clear_in  in  1  pulse; reinitialise snake.
- move_in  in  1  pulse; request head push.
- grow_in  in  1  sampled with move_in; 1 = keep tail.
- new_x_in  in  X_BITS  new head x, sampled with move_in.
- new_y_in  in  Y_BITS  new head y, sampled with move_in.
- query_idx_in  in  ADDR_W  segment index; 0 = head.
- busy_out  out  1  operation in progress.
- done_out  out  1  one-cycle completion pulse.
- self_hit_out  out  1  sticky self-collision flag.
- full_out  out  1  length_out == DEPTH.
- length_out  out  ADDR_W+1  current length.
- head_x_out  out  X_BITS  current head x.
- head_y_out  out  Y_BITS  current head y.
- query_x_out  out  X_BITS  queried segment x.
- query_y_out  out  Y_BITS  queried segment y.
- query_valid_out  out  1  query_idx_in < length_out.

Function
REQ-004 Storage SHALL be a DEPTH-entry circular buffer with head pointer hp; segment k is stored at (hp+k) mod DEPTH; a push decrements hp modulo DEPTH and writes at the new hp.
REQ-005 States SHALL be IDLE, INIT, SCAN, COMMIT; busy_out = 1 in every state except IDLE.
REQ-006 clear_in SHALL have priority in any state, aborting any operation without writing; next state INIT with hp=0, length 0, self_hit_out=0.
REQ-007 INIT SHALL write one segment per cycle, segment i = (START_X-i, START_Y) for i = 0..INIT_LEN-1; after the last write length_out=INIT_LEN, head=(START_X,START_Y), done_out=1 for the following cycle, state IDLE.
REQ-008 move_in SHALL be accepted only in IDLE with length_out > 0, self_hit_out = 0 and clear_in = 0; otherwise it is ignored with no effect.
REQ-009 Effective grow g = grow_in AND NOT full_out, latched at acceptance.
REQ-010 SCAN SHALL compare the latched new head with segments k = 0..C-1, one per cycle, where C = length_out-1+g (the vacating tail is excluded when g=0); SCAN always runs all C cycles and is skipped when C=0.
REQ-011 COMMIT, one cycle: on no match, push the head; length_out increments if g=1, else the tail is dropped with length unchanged; head outputs update. On any match, leave the buffer unchanged and set self_hit_out=1.
REQ-012 done_out SHALL pulse for the cycle after COMMIT with updated outputs visible; state IDLE, and a new move_in is accepted in that cycle.
REQ-013 Latency: move accepted in cycle T yields COMMIT at T+C+1 and done_out at T+C+2.
REQ-014 self_hit_out SHALL remain set until clear_in or reset.
REQ-015 Query port SHALL be registered with one-cycle latency; query_x/y_out are zero when query_valid_out = 0.
REQ-016 Wall and range checks on new_x_in / new_y_in SHALL NOT be performed; they are the caller's responsibility.

Reset
REQ-017 sys_reset SHALL asynchronously force: state IDLE, hp=0, length_out=0, head_x/y_out=0, query outputs 0, busy_out, done_out, self_hit_out and full_out all 0; buffer contents are don't-care.
REQ-018 After reset, moves SHALL be ignored until a clear completes.

Verification
REQ-019 Reset, clear pulse -> busy for 3 cycles, done_out pulse, length=3, query idx 2 = (28,22).
REQ-020 After clear, move (31,22) with grow=0 -> C=2, done_out 4 cycles after acceptance, length 3, head (31,22), query idx 2 = (29,22).
REQ-021 Move with grow=1 to (32,22) -> length 4, query idx 3 = (29,22); move into the tail cell (29,22) with grow=0 -> no hit; the same move with grow=1 -> self_hit_out=1, length unchanged, later moves ignored.
REQ-022 DEPTH=4, INIT_LEN=4: move with grow=1 -> treated as grow=0, length stays 4, full_out=1; 10 successive moves exercise hp wrap with correct queries.
REQ-023 Assert clear_in during SCAN -> no write, INIT restarts, done_out only after INIT; simultaneous clear_in and move_in in IDLE -> clear wins.
REQ-024 Assert sys_reset mid-SCAN -> outputs take reset values immediately.
